// File: rtl/shared_pkg.sv
// Shared types and default widths for the padding stage and its neighbours.
package shared_pkg;

  localparam int PAD_DATA_WIDTH = 16;
  localparam int PAD_ADDR_WIDTH = 12;
  localparam int PAD_DIM_WIDTH  = 8;
  localparam int PAD_PAD_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pad_state_t;

  // Configuration captured on an accepted start.
  typedef struct packed {
    logic [PAD_DIM_WIDTH-1:0]  h;
    logic [PAD_DIM_WIDTH-1:0]  w;
    logic [PAD_DIM_WIDTH-1:0]  c;
    logic [PAD_PAD_WIDTH-1:0]  pad;
    logic [PAD_ADDR_WIDTH-1:0] src_base;
    logic [PAD_ADDR_WIDTH-1:0] dst_base;
  } pad_cfg_t;

endpackage

// File: rtl/pad_scan_ctr.sv
// Nested x/y/c scan over the padded volume. x is innermost; one position per
// advance. Reports whether the current position is interior (maps to a source
// word) and whether it is the final position of the whole volume.
module pad_scan_ctr #(
  parameter int DIM_WIDTH = 8,
  parameter int PAD_WIDTH = 3
) (
  input  logic                 core_clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [DIM_WIDTH-1:0] h,
  input  logic [DIM_WIDTH-1:0] w,
  input  logic [DIM_WIDTH-1:0] c,
  input  logic [PAD_WIDTH-1:0] pad,
  output logic                 interior,
  output logic                 last
);

  // One extra bit so H+2P and W+2P never overflow.
  localparam int EW = DIM_WIDTH + 1;

  logic [EW-1:0]        pad_e;
  logic [EW-1:0]        hp;
  logic [EW-1:0]        wp;
  logic [EW-1:0]        x;
  logic [EW-1:0]        y;
  logic [DIM_WIDTH-1:0] ch;
  logic                 x_wrap;
  logic                 y_wrap;
  logic                 c_wrap;

  // Padded extents, wrap conditions and interior window test.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    pad_e    = EW'(pad);
    hp       = EW'(h) + (pad_e << 1);
    wp       = EW'(w) + (pad_e << 1);
    x_wrap   = (x == wp - EW'(1));
    y_wrap   = (y == hp - EW'(1));
    c_wrap   = (ch == c - DIM_WIDTH'(1));
    last     = x_wrap && y_wrap && c_wrap;
    interior = (y >= pad_e) && (y < pad_e + EW'(h)) &&
               (x >= pad_e) && (x < pad_e + EW'(w));
  end

  // Position counters: x wraps into y, y wraps into channel, no idle cycle.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      x  <= '0;
      y  <= '0;
      ch <= '0;
    end else if (clear) begin
      x  <= '0;
      y  <= '0;
      ch <= '0;
    end else if (advance) begin
      if (x_wrap) begin
        x <= '0;
        if (y_wrap) begin
          y  <= '0;
          ch <= c_wrap ? '0 : ch + DIM_WIDTH'(1);
        end else begin
          y <= y + EW'(1);
        end
      end else begin
        x <= x + EW'(1);
      end
    end
  end

endmodule

// File: rtl/pad_engine.sv
// Zero-padding stage: streams a CxHxW map from the GLB into a Cx(H+2P)x(W+2P)
// map at a second base address, one output word per cycle.
module pad_engine
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = PAD_DATA_WIDTH,
  parameter int ADDR_WIDTH = PAD_ADDR_WIDTH,
  parameter int DIM_WIDTH  = PAD_DIM_WIDTH,
  parameter int PAD_WIDTH  = PAD_PAD_WIDTH
) (
  input  logic                  core_clk,
  input  logic                  reset_n,
  input  logic                  enable_pad,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cfg_h,
  input  logic [DIM_WIDTH-1:0]  cfg_w,
  input  logic [DIM_WIDTH-1:0]  cfg_c,
  input  logic [PAD_WIDTH-1:0]  cfg_pad,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  pad_state_t            state;
  pad_state_t            state_nxt;
  pad_cfg_t              cfg_q;
  logic                  accept;
  logic                  zero_dim;
  logic                  in_run;
  logic                  scan_interior;
  logic                  scan_last;
  logic [ADDR_WIDTH-1:0] src_ctr;
  logic [ADDR_WIDTH-1:0] dst_ctr;
  logic                  wr_valid_q;
  logic                  wr_interior_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  done_q;

  pad_scan_ctr #(
    .DIM_WIDTH (DIM_WIDTH),
    .PAD_WIDTH (PAD_WIDTH)
  ) u_scan (
    .core_clk (core_clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .advance  (in_run),
    .h        (cfg_q.h),
    .w        (cfg_q.w),
    .c        (cfg_q.c),
    .pad      (cfg_q.pad),
    .interior (scan_interior),
    .last     (scan_last)
  );

  // Start qualification and next-state selection; enable_pad low aborts quietly.
  always_comb begin
    accept    = start && enable_pad && (state == IDLE);
    zero_dim  = (cfg_h == '0) || (cfg_w == '0) || (cfg_c == '0);
    in_run    = (state == RUN);
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = zero_dim ? DONE : RUN;
      RUN:     if (!enable_pad) state_nxt = IDLE;
               else if (scan_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = enable_pad ? DONE : IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Configuration capture on an accepted start.
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n)    cfg_q <= '0;
    else if (accept) cfg_q <= '{h: cfg_h, w: cfg_w, c: cfg_c, pad: cfg_pad,
                                src_base: src_base, dst_base: dst_base};
  end

  // Source and destination offsets; source advances only on interior positions.
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ctr <= '0;
      dst_ctr <= '0;
    end else if (accept) begin
      src_ctr <= '0;
      dst_ctr <= '0;
    end else if (in_run) begin
      dst_ctr <= dst_ctr + ADDR_WIDTH'(1);
      if (scan_interior) src_ctr <= src_ctr + ADDR_WIDTH'(1);
    end
  end

  // One-stage write pipeline aligned with the read data return; abort drops it.
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_valid_q    <= 1'b0;
      wr_interior_q <= 1'b0;
      wr_addr_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      wr_valid_q    <= in_run && enable_pad;
      wr_interior_q <= scan_interior;
      wr_addr_q     <= cfg_q.dst_base + dst_ctr;
      done_q        <= (state == DONE);
    end
  end

  // GLB request and status outputs.
  always_comb begin
    rd_en   = in_run && scan_interior;
    rd_addr = rd_en ? cfg_q.src_base + src_ctr : '0;
    wr_en   = wr_valid_q;
    wr_addr = wr_valid_q ? wr_addr_q : '0;
    wr_data = (wr_valid_q && wr_interior_q) ? rd_data : '0;
    busy    = (state != IDLE);
    done    = done_q;
  end

endmodule

// File: tb/tb_pad_engine.sv
// Bench for pad_engine: GLB memory model, per-cycle expectation queue built
// from the padding rules, plus literal checks on memory contents and timing.
module tb_pad_engine;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int MW = 8;
  localparam int PW = 3;

  typedef struct {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
  } exp_t;

  logic          core_clk = 1'b0;
  logic          reset_n  = 1'b0;
  logic          enable_pad = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] cfg_h = '0;
  logic [MW-1:0] cfg_w = '0;
  logic [MW-1:0] cfg_c = '0;
  logic [PW-1:0] cfg_pad = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] glb [0:(1<<AW)-1];
  exp_t          exp_q [$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_wr = 0;
  int            n_rd = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;

  pad_engine dut (
    .core_clk   (core_clk),
    .reset_n    (reset_n),
    .enable_pad (enable_pad),
    .start      (start),
    .cfg_h      (cfg_h),
    .cfg_w      (cfg_w),
    .cfg_c      (cfg_c),
    .cfg_pad    (cfg_pad),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 core_clk = ~core_clk;

  // GLB model: read data returns one cycle after rd_en; writes land at the edge.
  always @(posedge core_clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= glb[rd_addr];
    if (wr_en) glb[wr_addr] <= wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected per-cycle behaviour of one run, starting with the cycle after start.
  task automatic model_start(input int h, input int w, input int c, input int p,
                             input int src, input int dst);
    int   hp;
    int   wp;
    int   n;
    int   pos;
    int   k;
    bit   inner;
    logic [AW-1:0] a;
    exp_t e [];
    hp = h + 2 * p;
    wp = w + 2 * p;
    n  = c * hp * wp;
    e  = new[n + 3];
    foreach (e[i]) e[i] = '{default: '0};
    pos = 0;
    k   = 0;
    for (int ch = 0; ch < c; ch++)
      for (int y = 0; y < hp; y++)
        for (int x = 0; x < wp; x++) begin
          inner = (y >= p) && (y < p + h) && (x >= p) && (x < p + w);
          a = AW'(src + k);
          e[pos].busy = 1'b1;
          if (inner) begin
            e[pos].rd_en   = 1'b1;
            e[pos].rd_addr = a;
          end
          e[pos+1].wr_en   = 1'b1;
          e[pos+1].wr_addr = AW'(dst + pos);
          e[pos+1].wr_data = inner ? glb[a] : '0;
          if (inner) k++;
          pos++;
        end
    if (n == 0) begin
      e[0].busy = 1'b1;
      e[1].done = 1'b1;
    end else begin
      e[n].busy   = 1'b1;
      e[n+1].busy = 1'b1;
      e[n+2].done = 1'b1;
    end
    if (exp_q.size() == 0) exp_q.push_back('{default: '0});
    foreach (e[i]) exp_q.push_back(e[i]);
  endtask

  // Per-cycle comparison against the expectation queue (idle when empty).
  always @(negedge core_clk) begin
    exp_t e;
    e = '{default: '0};
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("busy", busy, e.busy);
    check("done", done, e.done);
    check("rd_en", rd_en, e.rd_en);
    check("wr_en", wr_en, e.wr_en);
    if (e.rd_en && rd_en) check("rd_addr", rd_addr, e.rd_addr);
    if (e.wr_en && wr_en) begin
      check("wr_addr", wr_addr, e.wr_addr);
      check("wr_data", wr_data, e.wr_data);
    end
    if (wr_en) n_wr++;
    if (rd_en) n_rd++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic do_start(input int h, input int w, input int c, input int p,
                          input int src, input int dst);
    @(posedge core_clk); #1;
    cfg_h    = MW'(h);
    cfg_w    = MW'(w);
    cfg_c    = MW'(c);
    cfg_pad  = PW'(p);
    src_base = AW'(src);
    dst_base = AW'(dst);
    start    = 1'b1;
    if (enable_pad && (exp_q.size() == 0 || !exp_q[0].busy)) begin
      start_cyc = cyc;
      model_start(h, w, c, p, src, dst);
    end
    @(posedge core_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int base;
    int i;
    base = done_cnt;
    i = 0;
    while (done_cnt == base && i < limit) begin
      @(posedge core_clk);
      i++;
    end
    check("done within bound", done_cnt != base, 1);
    @(posedge core_clk); #1;
  endtask

  task automatic fill(input int base, input int n, input int first, input int step);
    for (int i = 0; i < n; i++) glb[AW'(base + i)] <= DW'(first + i * step);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int t1 [16];
    t1 = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};
    for (int i = 0; i < (1 << AW); i++) glb[i] <= '0;
    #1;
    check("reset rd_en", rd_en, 0);
    check("reset wr_en", wr_en, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    repeat (2) @(posedge core_clk);
    #1 reset_n = 1'b1;
    enable_pad = 1'b1;

    // 2x2, one channel, pad 1.
    fill(0, 4, 1, 1);
    fill(100, 16, 16'hdead, 0);
    n_wr = 0; n_rd = 0;
    do_start(2, 2, 1, 1, 0, 100);
    wait_done(100);
    check("t1 writes", n_wr, 16);
    check("t1 reads", n_rd, 4);
    check("t1 latency", done_cyc - start_cyc, 19);
    for (int i = 0; i < 16; i++) check("t1 dst word", glb[100 + i], t1[i]);

    // 3x3, pad 0: straight copy.
    fill(200, 9, 10, 1);
    n_wr = 0; n_rd = 0;
    do_start(3, 3, 1, 0, 200, 300);
    wait_done(100);
    check("t2 writes", n_wr, 9);
    check("t2 reads", n_rd, 9);
    check("t2 latency", done_cyc - start_cyc, 12);
    for (int i = 0; i < 9; i++) check("t2 dst word", glb[300 + i], 10 + i);

    // 1x1, two channels, pad 1.
    glb[50] <= 16'd7;
    glb[51] <= 16'd9;
    fill(400, 18, 16'hdead, 0);
    n_wr = 0; n_rd = 0;
    do_start(1, 1, 2, 1, 50, 400);
    wait_done(100);
    check("t3 writes", n_wr, 18);
    check("t3 latency", done_cyc - start_cyc, 21);
    for (int i = 0; i < 18; i++)
      check("t3 dst word", glb[400 + i], (i == 4) ? 7 : (i == 13) ? 9 : 0);

    // Zero channels: no traffic, immediate completion.
    n_wr = 0; n_rd = 0;
    do_start(3, 3, 0, 1, 0, 500);
    wait_done(20);
    check("t4 writes", n_wr, 0);
    check("t4 reads", n_rd, 0);
    check("t4 latency", done_cyc - start_cyc, 2);

    // 4x4, pad 2, abort after ten writes, then a clean rerun.
    fill(600, 16, 16'h20, 1);
    n_wr = 0; n_rd = 0;
    do_start(4, 4, 1, 2, 600, 700);
    repeat (10) @(posedge core_clk);
    #1 enable_pad = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    begin
      int dc;
      dc = done_cnt;
      @(posedge core_clk); #1;
      check("abort rd_en", rd_en, 0);
      check("abort wr_en", wr_en, 0);
      check("abort busy", busy, 0);
      repeat (5) @(posedge core_clk);
      #1;
      check("abort writes", n_wr, 10);
      check("abort no done", done_cnt, dc);
    end
    enable_pad = 1'b1;
    n_wr = 0; n_rd = 0;
    do_start(4, 4, 1, 2, 600, 700);
    wait_done(200);
    check("t5 writes", n_wr, 64);
    check("t5 reads", n_rd, 16);
    check("t5 latency", done_cyc - start_cyc, 67);
    check("t5 corner", glb[700], 0);
    check("t5 first interior", glb[718], 16'h20);
    check("t5 last interior", glb[745], 16'h2f);
    check("t5 last word", glb[763], 0);

    // Second start in the middle of a run is ignored.
    fill(800, 16, 16'hdead, 0);
    glb[900] <= 16'hbeef;
    n_wr = 0; n_rd = 0;
    do_start(2, 2, 1, 1, 0, 800);
    repeat (3) @(posedge core_clk);
    do_start(3, 3, 5, 1, 0, 900);
    wait_done(100);
    check("t6 writes", n_wr, 16);
    check("t6 latency", done_cyc - start_cyc, 19);
    check("t6 dst interior", glb[805], 1);
    check("t6 other dst untouched", glb[900], 16'hbeef);

    repeat (3) @(posedge core_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pad_engine.md
Name: pad_engine

Overview:
- Hardware zero-padding stage that runs after max-pooling (and LRN) and before the next convolution layer.
- Reads a C×H×W ofmap from the global buffer (GLB) and writes a C×(H+2P)×(W+2P) padded ifmap back to the GLB at a separate base address.
- Active only while enable_pad is high; runs mutually exclusive with the NoC array and the LRN stage.
- Sustains one output word per cycle.

Parameters:
- DATA_WIDTH, 16, psum/activation word width
- ADDR_WIDTH, 12, GLB word address width
- DIM_WIDTH, 8, width of H, W, C configuration fields
- PAD_WIDTH, 3, width of pad-size field P

Ports:
- core_clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- enable_pad  in  1  stage enable (level); low aborts
- start  in  1  one-cycle pulse; latches config and begins
- cfg_h  in  DIM_WIDTH  input plane height H
- cfg_w  in  DIM_WIDTH  input plane width W
- cfg_c  in  DIM_WIDTH  channel count C
- cfg_pad  in  PAD_WIDTH  pad size P (all four sides)
- src_base  in  ADDR_WIDTH  GLB base address of unpadded data
- dst_base  in  ADDR_WIDTH  GLB base address of padded data
- rd_en  out  1  GLB read request
- rd_addr  out  ADDR_WIDTH  GLB read address
- rd_data  in  DATA_WIDTH  GLB read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  GLB write strobe
- wr_addr  out  ADDR_WIDTH  GLB write address
- wr_data  out  DATA_WIDTH  GLB write data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- FSM states:
  - IDLE: start && enable_pad → latch cfg_* and bases. Next state is RUN, or DONE if any of H, W, C is 0.
  - RUN: scan c in [0,C), y in [0,Hp), x in [0,Wp), with Hp=H+2P and Wp=W+2P. x is innermost. One position per cycle. Last position → DRAIN.
  - DRAIN: one cycle to retire the final pipeline write → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Interior position: P<=y<P+H and P<=x<P+W.
  - Interior: rd_en=1, rd_addr=src_base+src_ctr. src_ctr increments on every interior position.
  - Border: no read issued.
- Write pipeline: a 1-stage register carries {valid, interior, dst_addr}.
  - The next cycle drives wr_en=1, wr_addr=dst_base+dst_ctr.
  - wr_data=rd_data if interior, else 0.
  - dst_ctr increments on every position.
- Timing:
  - First wr_en occurs 2 cycles after the start cycle.
  - Total cycles from start to done pulse = C·Hp·Wp + 3.
  - Exactly C·Hp·Wp writes and C·H·W reads are issued.
- Arithmetic:
  - Hp/Wp computed at DIM_WIDTH+1 bits.
  - Addresses computed modulo 2^ADDR_WIDTH; wrap is silent.
- Boundary conditions:
  - P=0: pure copy.
  - Channel boundary: x/y counters wrap to 0, c increments; no idle cycle between channels.
  - start while busy: ignored.
  - start with enable_pad low: ignored.
  - enable_pad falls in RUN/DRAIN: next cycle → IDLE, rd_en/wr_en forced 0, no done pulse, partial output left in GLB.
  - reset_n low at any time: immediate return to reset state.
- busy=1 in RUN, DRAIN, DONE.

Decomposition:
- shared_pkg (team-wide):
  - pad_state_t enum {IDLE, RUN, DRAIN, DONE}
  - pad_cfg_t struct {h, w, c, pad, src_base, dst_base}
  - DATA_WIDTH/ADDR_WIDTH defaults
- One natural sub-module: pad_scan_ctr.
  - Nested x/y/c counter with wrap flags and interior flag.
  - pad_engine holds the FSM, address counters and write pipeline.

Test Plan:
- H=W=2, C=1, P=1, src=0 holding {1,2,3,4}, dst=100:
  - 16 writes to 100..115.
  - Data 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0.
  - 4 reads at 0..3.
  - done exactly 19 cycles after start.
- H=W=3, C=1, P=0: 9 reads and 9 writes; dst mirrors src in order; done 12 cycles after start.
- H=W=1, C=2, P=1, src={7,9}:
  - 18 writes with no gap between channels.
  - Only dst offsets 4 (=7) and 13 (=9) are non-zero.
- cfg_c=0: no rd_en/wr_en; done 2 cycles after start.
- H=W=4, C=1, P=2, enable_pad dropped after 10 writes:
  - Next cycle rd_en/wr_en=0, busy=0, no done.
  - Then a new start with enable_pad high completes normally with 64 writes.
- Second start pulse mid-RUN: ignored; write count and done timing unchanged from a single run.
